// File: rtl/instr_dispatcher.sv
// Instruction dispatcher: buffers instructions in a FIFO and issues them one at a time
// when the snooped coherence bus is quiet. Optional statistics counters via DISPATCH_STATS_EN.
module instr_dispatcher #(
    parameter int DEPTH        = 8,
    parameter int QUIET_CYCLES = 2,
    parameter int TIMEOUT      = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [6:0]  in_instr,
    output logic        in_ready,
    input  logic [10:0] busWire,
    output logic [6:0]  instrucao,
    output logic        busy,
`ifdef DISPATCH_STATS_EN
    output logic [7:0]  rd_count,
    output logic [7:0]  wr_count,
`endif
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [QW-1:0] QMAX    = QW'(QUIET_CYCLES);
    localparam logic [WW-1:0] TMAX    = WW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d, avail;
    logic          push_q;
    logic [QW-1:0] quiet_cnt_q, quiet_cnt_d, quiet_inc;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]    instr_q, instr_d;
    logic          timeout_q, timeout_d;
    logic          push, pop, bus_quiet;
    logic          unused_bus;

    assign unused_bus = ^{busWire[10:8], busWire[6], busWire[3:0]};

    assign in_ready    = (count_q < DEPTH_C);
    assign push        = in_valid && in_ready && (in_instr[6:5] != 2'b00);
    assign bus_quiet   = (busWire[5:4] == 2'b00) && !busWire[7];
    assign count_d     = count_q + CW'(push) - CW'(pop);
    // The newest write stays hidden from the issue logic for one cycle (write-to-read latency).
    assign avail       = count_q - CW'(push_q);
    assign quiet_inc   = !bus_quiet ? '0 :
                         (quiet_cnt_q == QMAX) ? QMAX : quiet_cnt_q + QW'(1);

    assign instrucao   = instr_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        instr_d     = 7'b0000000;
        timeout_d   = 1'b0;
        quiet_cnt_d = quiet_inc;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if ((avail != '0) && (quiet_cnt_q == QMAX)) begin
                    pop     = 1'b1;
                    instr_d = mem_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                quiet_cnt_d = '0;
                wait_cnt_d  = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                // A quiet exit takes priority over a coincident timeout.
                if (quiet_inc == QMAX) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_d == TMAX) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            push_q      <= 1'b0;
            quiet_cnt_q <= QMAX;
            wait_cnt_q  <= '0;
            instr_q     <= 7'b0000000;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            push_q      <= push;
            quiet_cnt_q <= quiet_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_q     <= instr_d;
            timeout_q   <= timeout_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [7:0] rd_count_q, wr_count_q;

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (pop) begin
            if (instr_d[4]) wr_count_q <= wr_count_q + 8'd1;
            else            rd_count_q <= rd_count_q + 8'd1;
        end
    end
`endif

endmodule

// File: doc/instr_dispatcher.md
INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; a power of two, at least 2.
REQ-002 Parameter QUIET_CYCLES, default 2, consecutive quiet bus cycles required before an issue; at least 1.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before a forced return to IDLE; greater than QUIET_CYCLES.
REQ-004 clock  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_instr.
REQ-007 in_instr  input  7  instruction: [6:5] processor code, [4] opcode (0 read, 1 write), [3] tag, [2:0] data.
REQ-008 in_ready  output  1  dispatcher can accept; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-009 busWire  input  11  arbitrated coherence bus, snooped only; [7] writeback, [5:4] bus message.
REQ-010 instrucao  output  7  registered instruction to the processors; 7'b0000000 means no instruction.
REQ-011 busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
REQ-012 timeout_err  output  1  one-cycle pulse when WAIT ends by timeout.

Function
REQ-013 in_ready SHALL equal (count < DEPTH); an accepted instruction with [6:5]=00 SHALL be discarded and not stored.
REQ-014 The FIFO SHALL be first-in first-out with wrapping pointers; a push and a pop in the same cycle leave count unchanged.
REQ-015 There SHALL be no bypass: an entry becomes poppable no earlier than the edge after its push.
REQ-016 Bus quiet is defined as busWire[5:4]=00 and busWire[7]=0.
REQ-017 quiet_cnt SHALL increment on each quiet cycle, saturating at QUIET_CYCLES, and SHALL clear to 0 on any non-quiet cycle.
REQ-018 FSM states are IDLE, ISSUE and WAIT.
REQ-019 IDLE -> ISSUE when the FIFO is non-empty and quiet_cnt = QUIET_CYCLES; otherwise the FSM stays in IDLE.
REQ-020 On the IDLE -> ISSUE edge, the FIFO head SHALL be popped and registered into instrucao.
REQ-021 ISSUE -> WAIT unconditionally; instrucao SHALL be non-zero for exactly the one cycle spent in ISSUE, and 0 in every other cycle.
REQ-022 On entry to WAIT, quiet_cnt and wait_cnt SHALL clear to 0; wait_cnt increments every cycle spent in WAIT.
REQ-023 WAIT -> IDLE when quiet_cnt reaches QUIET_CYCLES.
REQ-024 WAIT -> IDLE with a timeout_err pulse when wait_cnt reaches TIMEOUT; when both conditions hold in the same cycle, the quiet exit SHALL win and no pulse is produced.
REQ-025 Minimum spacing between consecutive issues SHALL be 2+QUIET_CYCLES cycles.
REQ-026 Latency: with the FIFO empty, the FSM in IDLE and the bus saturated quiet, an instruction accepted at edge N SHALL drive instrucao after edge N+2.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL apply: FIFO emptied (pointers and count 0), FSM=IDLE, instrucao=0, timeout_err=0, wait_cnt=0, quiet_cnt=QUIET_CYCLES; in_ready=1 and busy=0 in the following cycle.
REQ-028 Reset SHALL override any simultaneous push, pop or issue, including an issue in progress.

Configuration
REQ-029 Macro DISPATCH_STATS_EN defined: add outputs rd_count[7:0] and wr_count[7:0], incremented on each ISSUE by opcode, wrapping 255 -> 0, cleared by reset.
REQ-030 Macro DISPATCH_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Single read 7'b0100101 on an idle bus, accepted at edge 0 -> instrucao=0100101 for one cycle after edge 2; busy returns low after QUIET_CYCLES quiet cycles.
REQ-032 Push 9 entries back-to-back with the bus held busy (busWire[5:4]=01) -> in_ready=0 after the 8th; no issue occurs; order is preserved on release.
REQ-033 Hold busWire[5:4]=11 for 20 cycles after an issue -> timeout_err pulses once 15 cycles into WAIT, then the FSM is IDLE.
REQ-034 Push 7'b0011111 (code 00) -> accepted, count stays 0, nothing issued.
REQ-035 Assert reset during ISSUE with 3 entries queued -> next cycle: instrucao=0, count=0, in_ready=1, and no further issues.
REQ-036 With DISPATCH_STATS_EN, issue 256 writes -> wr_count=0 and rd_count=0.
